// File: rtl/rsa_modexp_pkg.sv
// Shared definitions for the modular exponentiation engine: default widths,
// FSM state encoding and a latency helper used by benches.
package rsa_pkg;

  localparam int RSA_W     = 16;
  localparam int RSA_EXP_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REDUCE,
    ST_SQUARE,
    ST_MULT,
    ST_FINISH
  } modexp_state_t;

  // Cycles from the accepted start to the done pulse on the non-error path.
  function automatic int modexp_latency(input int w, input int exp_w,
                                        input int popcnt, input int const_time);
    int nOps;
    nOps = (const_time != 0) ? (1 + 2 * exp_w) : (1 + exp_w + popcnt);
    return 2 + (w + 2) * nOps;
  endfunction

endpackage

// File: rtl/rsa_modexp_modmul_blakley.sv
// Blakley interleaved modular multiplier: one bit of a per cycle, MSB first,
// producing a*b mod n in W cycles after mm_start (requires b < n).
module modmul_blakley
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mm_start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         mm_done,
  output logic [W-1:0] p
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_n;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_done;

  logic [W+1:0]  w_sum;
  logic [W+1:0]  w_sub1;
  logic [W-1:0]  w_next;

  // 2R + a_i*b stays below 3n, so two conditional subtractions reduce it fully.
  always_comb begin
    w_sum  = {1'b0, r_acc, 1'b0} + (r_a[W-1] ? {2'b00, r_b} : '0);
    w_sub1 = (w_sum >= {2'b00, r_n}) ? (w_sum - {2'b00, r_n}) : w_sum;
    w_next = W'((w_sub1 >= {2'b00, r_n}) ? (w_sub1 - {2'b00, r_n}) : w_sub1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_n    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (mm_start) begin
        r_a   <= a;
        r_b   <= b;
        r_n   <= n;
        r_acc <= '0;
        r_cnt <= CW'(W);
      end else if (r_cnt != '0) begin
        r_acc <= w_next;
        r_a   <= {r_a[W-2:0], 1'b0};
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) r_done <= 1'b1;
      end
    end
  end

  assign mm_done = r_done;
  assign p       = r_acc;

endmodule

// File: rtl/rsa_modexp.sv
// Left-to-right square-and-multiply engine computing base^exponent mod modulus
// on one shared Blakley multiplier, with optional constant-time bit handling.
module rsa_modexp
  import rsa_pkg::*;
#(
  parameter int W          = RSA_W,
  parameter int EXP_W      = RSA_EXP_W,
  parameter int CONST_TIME = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     base,
  input  logic [EXP_W-1:0] exponent,
  input  logic [W-1:0]     modulus,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     result,
  output logic             error
);

  localparam int CW = $clog2(EXP_W + 1);

  modexp_state_t    r_state;
  logic [W-1:0]     r_base;
  logic [W-1:0]     r_mod;
  logic [EXP_W-1:0] r_exp;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_b;
  logic [CW-1:0]    r_bitsLeft;
  logic             r_mmStart;
  logic             r_busy;
  logic             r_done;
  logic [W-1:0]     r_result;
  logic             r_error;

  logic [W-1:0]     w_mmA;
  logic [W-1:0]     w_mmB;
  logic [W-1:0]     w_mmP;
  logic             w_mmDone;
  logic             w_bit;
  logic             w_lastBit;
  logic [W-1:0]     w_multAcc;

  assign w_bit     = r_exp[EXP_W-1];
  assign w_lastBit = (r_bitsLeft == CW'(1));
  assign w_multAcc = w_bit ? w_mmP : r_acc;

  // REDUCE multiplies by 1 so that any base, even >= n, becomes a legal b operand.
  always_comb begin
    w_mmA = r_acc;
    w_mmB = r_b;
    if (r_state == ST_REDUCE) begin
      w_mmA = r_base;
      w_mmB = W'(1);
    end else if (r_state == ST_SQUARE) begin
      w_mmB = r_acc;
    end
  end

  modmul_blakley #(.W(W)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .mm_start (r_mmStart),
    .a        (w_mmA),
    .b        (w_mmB),
    .n        (r_mod),
    .mm_done  (w_mmDone),
    .p        (w_mmP)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_mod      <= '0;
      r_exp      <= '0;
      r_acc      <= '0;
      r_b        <= '0;
      r_bitsLeft <= '0;
      r_mmStart  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_error    <= 1'b0;
    end else begin
      r_mmStart <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base  <= base;
            r_mod   <= modulus;
            r_exp   <= exponent;
            r_busy  <= 1'b1;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (r_mod < W'(2)) begin
            r_error  <= 1'b1;
            r_result <= '0;
            r_done   <= 1'b1;
            r_state  <= ST_FINISH;
          end else begin
            r_acc      <= W'(1);
            r_bitsLeft <= CW'(EXP_W);
            r_mmStart  <= 1'b1;
            r_state    <= ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          if (w_mmDone) begin
            r_b       <= w_mmP;
            r_mmStart <= 1'b1;
            r_state   <= ST_SQUARE;
          end
        end
        ST_SQUARE: begin
          if (w_mmDone) begin
            r_acc <= w_mmP;
            if (w_bit || (CONST_TIME != 0)) begin
              r_mmStart <= 1'b1;
              r_state   <= ST_MULT;
            end else if (w_lastBit) begin
              r_result <= w_mmP;
              r_error  <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= ST_FINISH;
            end else begin
              r_exp      <= r_exp << 1;
              r_bitsLeft <= r_bitsLeft - CW'(1);
              r_mmStart  <= 1'b1;
              r_state    <= ST_SQUARE;
            end
          end
        end
        // In constant-time mode a zero bit still multiplies; the product is dropped.
        ST_MULT: begin
          if (w_mmDone) begin
            r_acc <= w_multAcc;
            if (w_lastBit) begin
              r_result <= w_multAcc;
              r_error  <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= ST_FINISH;
            end else begin
              r_exp      <= r_exp << 1;
              r_bitsLeft <= r_bitsLeft - CW'(1);
              r_mmStart  <= 1'b1;
              r_state    <= ST_SQUARE;
            end
          end
        end
        ST_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign error  = r_error;

endmodule

// File: tb/tb_rsa_modexp.sv
// Self-checking bench for rsa_modexp: three instances (16-bit, 16-bit
// constant-time, 32-bit) checked every cycle against a square-and-multiply model.
module tb_rsa_modexp;
  import rsa_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [2:0]       startV;
  logic [2:0][31:0] baseV;
  logic [2:0][31:0] expV;
  logic [2:0][31:0] modV;
  wire  [2:0]       busyV;
  wire  [2:0]       doneV;
  wire  [2:0]       errorV;
  wire  [2:0][31:0] resultV;
  logic [15:0]      res0;
  logic [15:0]      res1;
  logic [31:0]      res2;

  assign resultV[0] = {16'h0, res0};
  assign resultV[1] = {16'h0, res1};
  assign resultV[2] = res2;

  rsa_modexp #(.W(16), .EXP_W(16), .CONST_TIME(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(startV[0]),
    .base(baseV[0][15:0]), .exponent(expV[0][15:0]), .modulus(modV[0][15:0]),
    .busy(busyV[0]), .done(doneV[0]), .result(res0), .error(errorV[0]));

  rsa_modexp #(.W(16), .EXP_W(16), .CONST_TIME(1)) dutCt (
    .clk(clk), .rst_n(rst_n), .start(startV[1]),
    .base(baseV[1][15:0]), .exponent(expV[1][15:0]), .modulus(modV[1][15:0]),
    .busy(busyV[1]), .done(doneV[1]), .result(res1), .error(errorV[1]));

  rsa_modexp #(.W(32), .EXP_W(32), .CONST_TIME(0)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(startV[2]),
    .base(baseV[2]), .exponent(expV[2]), .modulus(modV[2]),
    .busy(busyV[2]), .done(doneV[2]), .result(res2), .error(errorV[2]));

  int wOf   [3] = '{16, 16, 32};
  int expWOf[3] = '{16, 16, 32};
  int ctOf  [3] = '{0, 1, 0};

  int          cyc = 0;
  int          testsRun = 0;
  int          testsFailed = 0;
  bit          checkEn = 1'b0;
  bit          pending [3];
  int          acceptCyc [3];
  int          doneCyc [3];
  int          lastDone [3];
  int          seenDone [3];
  logic [31:0] expRes [3];
  logic [31:0] heldRes [3];
  logic        expErr [3];
  logic        heldErr [3];

  always @(posedge clk) cyc <= cyc + 1;

  // Plain right-to-left-free square-and-multiply over 64-bit integers.
  function automatic logic [31:0] refModExp(input logic [31:0] b, input logic [31:0] e,
                                            input logic [31:0] m);
    logic [63:0] r;
    logic [63:0] x;
    r = 64'd1;
    x = {32'd0, b} % {32'd0, m};
    for (int k = 31; k >= 0; k--) begin
      r = (r * r) % {32'd0, m};
      if (e[k]) r = (r * x) % {32'd0, m};
    end
    return r[31:0];
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s[%0d] cycle %0d: got %0d (0x%0h), expected %0d (0x%0h)",
               name, idx, cyc, act, act, exp, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin : compare
    bit eBusy;
    bit eDone;
    if (checkEn) begin
      for (int i = 0; i < 3; i++) begin
        eBusy = pending[i] && (cyc > acceptCyc[i]);
        eDone = pending[i] && (cyc == doneCyc[i]);
        if (eDone) begin
          heldRes[i] = expRes[i];
          heldErr[i] = expErr[i];
        end
        if (doneV[i] === 1'b1) seenDone[i] = cyc;
        checkOutput("busy", i, {31'd0, busyV[i]}, {31'd0, eBusy});
        checkOutput("done", i, {31'd0, doneV[i]}, {31'd0, eDone});
        checkOutput("result", i, resultV[i], heldRes[i]);
        checkOutput("error", i, {31'd0, errorV[i]}, {31'd0, heldErr[i]});
        if (eDone) begin
          pending[i]  = 1'b0;
          lastDone[i] = cyc;
        end
      end
    end
  end

  task automatic applyStimulus(input int i, input logic [31:0] b,
                               input logic [31:0] e, input logic [31:0] m);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((pending[i] || cyc <= lastDone[i]) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL idleWait[%0d]: engine still busy after %0d cycles, required idle", i, guard);
    end
    startV[i]    = 1'b1;
    baseV[i]     = b;
    expV[i]      = e;
    modV[i]      = m;
    acceptCyc[i] = cyc;
    seenDone[i]  = -1;
    expErr[i]    = (m < 32'd2);
    expRes[i]    = expErr[i] ? 32'd0 : refModExp(b, e, m);
    doneCyc[i]   = cyc + (expErr[i] ? 2
                   : modexp_latency(wOf[i], expWOf[i], $countones(e), ctOf[i]));
    pending[i]   = 1'b1;
    @(negedge clk);
    startV[i] = 1'b0;
  endtask

  task automatic waitDone(input int i);
    int guard;
    guard = 0;
    while (pending[i] && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (pending[i]) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL doneWait[%0d]: no completion within %0d cycles, required done", i, guard);
      pending[i] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic expectLiteral(input int i, input logic [31:0] res, input logic err, input int lat);
    waitDone(i);
    checkOutput("litResult", i, resultV[i], res);
    checkOutput("litError", i, {31'd0, errorV[i]}, {31'd0, err});
    checkOutput("litLatency", i, seenDone[i] - acceptCyc[i], lat);
  endtask

  initial begin
    logic [31:0] rb;
    logic [31:0] re;
    logic [31:0] rm;
    rst_n  = 1'b0;
    startV = '0;
    baseV  = '0;
    expV   = '0;
    modV   = '0;
    for (int i = 0; i < 3; i++) begin
      pending[i]  = 1'b0;
      acceptCyc[i] = 0;
      doneCyc[i]  = 0;
      lastDone[i] = -1;
      seenDone[i] = -1;
      expRes[i]   = '0;
      heldRes[i]  = '0;
      expErr[i]   = 1'b0;
      heldErr[i]  = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    checkEn = 1'b1;

    $display("[TB] directed vectors, 16-bit engine");
    applyStimulus(0, 32'd65, 32'd17, 32'd3233);
    expectLiteral(0, 32'd2790, 1'b0, 344);
    applyStimulus(0, 32'd2790, 32'd2753, 32'd3233);
    expectLiteral(0, 32'd65, 1'b0, 2 + 18 * 22);
    applyStimulus(0, 32'd3300, 32'd1, 32'd3233);
    applyStimulus(0, 32'd5, 32'd0, 32'd3233);
    expectLiteral(0, 32'd1, 1'b0, 2 + 18 * 17);
    applyStimulus(0, 32'd1234, 32'd99, 32'd1);
    expectLiteral(0, 32'd0, 1'b1, 2);
    applyStimulus(0, 32'd3300, 32'd1, 32'd3233);
    expectLiteral(0, 32'd67, 1'b0, 2 + 18 * 18);
    applyStimulus(0, 32'd77, 32'hFFFF, 32'd0);
    expectLiteral(0, 32'd0, 1'b1, 2);

    $display("[TB] constant-time engine");
    applyStimulus(1, 32'd2790, 32'd2753, 32'd3233);
    expectLiteral(1, 32'd65, 1'b0, 596);
    applyStimulus(1, 32'd65, 32'd17, 32'd3233);
    expectLiteral(1, 32'd2790, 1'b0, 596);

    $display("[TB] start while busy is ignored");
    applyStimulus(0, 32'd65, 32'd17, 32'd3233);
    repeat (100) @(negedge clk);
    startV[0] = 1'b1;
    baseV[0]  = 32'd7;
    expV[0]   = 32'd3;
    modV[0]   = 32'd11;
    @(negedge clk);
    startV[0] = 1'b0;
    expectLiteral(0, 32'd2790, 1'b0, 344);

    $display("[TB] reset mid-operation");
    applyStimulus(0, 32'd2790, 32'd2753, 32'd3233);
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      pending[i] = 1'b0;
      heldRes[i] = '0;
      heldErr[i] = 1'b0;
    end
    @(negedge clk);
    checkOutput("busyAfterReset", 0, {31'd0, busyV[0]}, 32'd0);
    rst_n = 1'b1;
    repeat (450) @(negedge clk);
    applyStimulus(0, 32'd3300, 32'd1, 32'd3233);
    expectLiteral(0, 32'd67, 1'b0, 2 + 18 * 18);

    $display("[TB] 32-bit vectors");
    for (int v = 0; v < 12; v++) begin
      rb = $urandom;
      re = $urandom;
      if (v == 5)          rm = 32'd1;
      else if (v % 3 == 0) rm = $urandom_range(2, 255);
      else                 rm = $urandom | 32'h1;
      applyStimulus(2, rb, re, rm);
    end
    waitDone(2);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
